// File: rtl/apb_parity_scrub_arb.sv
`default_nettype none
// ============================================================================
// Module      : apb_parity_scrub_arb
// Description : Arbitrates a host APB slave port and an internal periodic
//               parity scrubber onto one APB master port feeding a register
//               block. Captures the first parity error seen on any read.
//               Optional macro PARITY_ERR_COUNT_EN adds a 16-bit saturating
//               parity error counter output (err_count).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_parity_scrub_arb #(
  parameter int G_ADDR_WIDTH     = 13,
  parameter int G_NUM_REGS       = 16,
  parameter int G_SCRUB_INTERVAL = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // host APB slave request
  input  logic                    s_apb_psel,
  input  logic                    s_apb_penable,
  input  logic                    s_apb_pwrite,
  input  logic [2:0]              s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0] s_apb_paddr,
  input  logic [31:0]             s_apb_pwdata,
  input  logic [3:0]              s_apb_pstrb,
  // host APB slave response
  output logic                    s_apb_pready,
  output logic [31:0]             s_apb_prdata,
  output logic                    s_apb_pslverr,
  // master towards the register block
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
  output logic [31:0]             m_apb_pwdata,
  output logic [3:0]              m_apb_pstrb,
  input  logic                    m_apb_pready,
  input  logic [31:0]             m_apb_prdata,
  input  logic                    m_apb_pslverr,
  // parity / scrub control and status
  input  logic                    parity_error,
  input  logic                    scrub_enable,
  input  logic                    err_clear,
  output logic                    err_valid,
  output logic [G_ADDR_WIDTH-1:0] err_addr,
  output logic                    err_src,
`ifdef PARITY_ERR_COUNT_EN
  output logic [15:0]             err_count,
`endif
  output logic                    busy
);

  localparam int c_IDX_W = (G_NUM_REGS > 1) ? $clog2(G_NUM_REGS) : 1;
  localparam int c_CNT_W = (G_SCRUB_INTERVAL > 1) ? $clog2(G_SCRUB_INTERVAL) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(G_NUM_REGS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(G_SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_HOST_SETUP   = 3'd1,
    ST_HOST_ACCESS  = 3'd2,
    ST_SCRUB_SETUP  = 3'd3,
    ST_SCRUB_ACCESS = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [G_ADDR_WIDTH-1:0] r_h_addr;
  logic [31:0]             r_h_wdata;
  logic                    r_h_write;
  logic [3:0]              r_h_strb;
  logic [2:0]              r_h_prot;

  logic [c_IDX_W-1:0]      r_scrub_idx;
  logic [c_CNT_W-1:0]      r_int_cnt;
  logic                    r_scrub_pending;

  logic                    r_err_valid;
  logic [G_ADDR_WIDTH-1:0] r_err_addr;
  logic                    r_err_src;

  logic                    w_scrub_start;
  logic                    w_scrub_done;
  logic                    w_host_done;
  logic                    w_rd_done;
  logic                    w_perr;
  logic                    w_cnt_expire;
  logic [G_ADDR_WIDTH-1:0] w_scrub_addr;
  logic                    w_unused;

  // The host phase signal is not needed: a request is recognised on psel alone.
  assign w_unused     = s_apb_penable;

  assign w_scrub_addr = G_ADDR_WIDTH'({r_scrub_idx, 2'b00});
  assign w_cnt_expire = (r_int_cnt == c_CNT_LAST);

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and master-side APB drive (all zero when idle).
  always_comb begin
    w_state_nxt   = r_state;
    w_scrub_start = 1'b0;
    w_scrub_done  = 1'b0;
    m_apb_psel    = 1'b0;
    m_apb_penable = 1'b0;
    m_apb_pwrite  = 1'b0;
    m_apb_pprot   = 3'b000;
    m_apb_paddr   = '0;
    m_apb_pwdata  = 32'h0;
    m_apb_pstrb   = 4'h0;
    case (r_state)
      ST_IDLE: begin
        if (s_apb_psel) begin
          w_state_nxt = ST_HOST_SETUP;
        end else if (r_scrub_pending) begin
          w_state_nxt   = ST_SCRUB_SETUP;
          w_scrub_start = 1'b1;
        end
      end
      ST_HOST_SETUP, ST_HOST_ACCESS: begin
        m_apb_psel    = 1'b1;
        m_apb_penable = (r_state == ST_HOST_ACCESS);
        m_apb_pwrite  = r_h_write;
        m_apb_pprot   = r_h_prot;
        m_apb_paddr   = r_h_addr;
        m_apb_pwdata  = r_h_wdata;
        m_apb_pstrb   = r_h_strb;
        if (r_state == ST_HOST_SETUP)  w_state_nxt = ST_HOST_ACCESS;
        else if (m_apb_pready)         w_state_nxt = ST_IDLE;
      end
      ST_SCRUB_SETUP, ST_SCRUB_ACCESS: begin
        m_apb_psel    = 1'b1;
        m_apb_penable = (r_state == ST_SCRUB_ACCESS);
        m_apb_paddr   = w_scrub_addr;
        if (r_state == ST_SCRUB_SETUP) begin
          w_state_nxt = ST_SCRUB_ACCESS;
        end else if (m_apb_pready) begin
          w_state_nxt  = ST_IDLE;
          w_scrub_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the host request when it is accepted from idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_addr  <= '0;
      r_h_wdata <= 32'h0;
      r_h_write <= 1'b0;
      r_h_strb  <= 4'h0;
      r_h_prot  <= 3'b000;
    end else if ((r_state == ST_IDLE) && s_apb_psel) begin
      r_h_addr  <= s_apb_paddr;
      r_h_wdata <= s_apb_pwdata;
      r_h_write <= s_apb_pwrite;
      r_h_strb  <= s_apb_pstrb;
      r_h_prot  <= s_apb_pprot;
    end
  end

  // Host response is passed straight through on completion; gated by rst so an
  // aborted transfer never produces a ready pulse.
  assign w_host_done   = (r_state == ST_HOST_ACCESS) && m_apb_pready && !rst;
  assign s_apb_pready  = w_host_done;
  assign s_apb_prdata  = w_host_done ? m_apb_prdata : 32'h0;
  assign s_apb_pslverr = w_host_done & m_apb_pslverr;
  assign busy          = (r_state != ST_IDLE);

  // Interval timer; a request already pending absorbs further expiries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_cnt       <= '0;
      r_scrub_pending <= 1'b0;
    end else if (!scrub_enable) begin
      r_scrub_pending <= 1'b0;
    end else begin
      r_int_cnt <= w_cnt_expire ? '0 : (r_int_cnt + 1'b1);
      if (w_scrub_start)     r_scrub_pending <= 1'b0;
      else if (w_cnt_expire) r_scrub_pending <= 1'b1;
    end
  end

  // Scrub pointer walks all registers, wrapping after the last one.
  always_ff @(posedge clk) begin
    if (rst)               r_scrub_idx <= '0;
    else if (w_scrub_done) r_scrub_idx <= (r_scrub_idx == c_IDX_LAST) ? '0 : (r_scrub_idx + 1'b1);
  end

  assign w_rd_done = m_apb_psel & m_apb_penable & m_apb_pready & ~m_apb_pwrite;
  assign w_perr    = w_rd_done & parity_error;

  // First-error capture; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_src   <= 1'b0;
    end else if (w_perr && (!r_err_valid || err_clear)) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= m_apb_paddr;
      r_err_src   <= (r_state == ST_SCRUB_ACCESS);
    end else if (err_clear) begin
      r_err_valid <= 1'b0;
    end
  end

  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign err_src   = r_err_src;

`ifdef PARITY_ERR_COUNT_EN
  logic [15:0] r_err_count;

  // Saturating count of every parity error; clear takes effect before increment.
  always_ff @(posedge clk) begin
    if (rst)                                  r_err_count <= 16'h0;
    else if (err_clear)                       r_err_count <= w_perr ? 16'd1 : 16'd0;
    else if (w_perr && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
  end

  assign err_count = r_err_count;
`else
  // No error counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_parity_scrub_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_parity_scrub_arb
// Description : Directed self-checking bench for apb_parity_scrub_arb with a
//               small register-block responder (programmable wait states,
//               per-address parity faults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_parity_scrub_arb;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_apb_psel, s_apb_penable, s_apb_pwrite;
  logic [2:0]    s_apb_pprot;
  logic [AW-1:0] s_apb_paddr;
  logic [31:0]   s_apb_pwdata;
  logic [3:0]    s_apb_pstrb;
  logic          s_apb_pready, s_apb_pslverr;
  logic [31:0]   s_apb_prdata;
  logic          m_apb_psel, m_apb_penable, m_apb_pwrite;
  logic [2:0]    m_apb_pprot;
  logic [AW-1:0] m_apb_paddr;
  logic [31:0]   m_apb_pwdata;
  logic [3:0]    m_apb_pstrb;
  logic          m_apb_pready, m_apb_pslverr;
  logic [31:0]   m_apb_prdata;
  logic          parity_error, scrub_enable, err_clear;
  logic          err_valid, err_src, busy;
  logic [AW-1:0] err_addr;
`ifdef PARITY_ERR_COUNT_EN
  logic [15:0]   err_count;
`endif

  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            rdy_delay = 0;
  int            wait_cnt = 0;
  logic [3:0]    perr_mask = 4'h0;
  logic [31:0]   rdata_val = 32'hDEADBEEF;
  logic          slverr_val = 1'b0;
  logic          mon_en = 1'b0;
  logic [AW-1:0] q_addr[$];
  int            q_cyc[$];

  apb_parity_scrub_arb #(
    .G_ADDR_WIDTH    (AW),
    .G_NUM_REGS      (4),
    .G_SCRUB_INTERVAL(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_apb_psel   (s_apb_psel),
    .s_apb_penable(s_apb_penable),
    .s_apb_pwrite (s_apb_pwrite),
    .s_apb_pprot  (s_apb_pprot),
    .s_apb_paddr  (s_apb_paddr),
    .s_apb_pwdata (s_apb_pwdata),
    .s_apb_pstrb  (s_apb_pstrb),
    .s_apb_pready (s_apb_pready),
    .s_apb_prdata (s_apb_prdata),
    .s_apb_pslverr(s_apb_pslverr),
    .m_apb_psel   (m_apb_psel),
    .m_apb_penable(m_apb_penable),
    .m_apb_pwrite (m_apb_pwrite),
    .m_apb_pprot  (m_apb_pprot),
    .m_apb_paddr  (m_apb_paddr),
    .m_apb_pwdata (m_apb_pwdata),
    .m_apb_pstrb  (m_apb_pstrb),
    .m_apb_pready (m_apb_pready),
    .m_apb_prdata (m_apb_prdata),
    .m_apb_pslverr(m_apb_pslverr),
    .parity_error (parity_error),
    .scrub_enable (scrub_enable),
    .err_clear    (err_clear),
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_src      (err_src),
`ifdef PARITY_ERR_COUNT_EN
    .err_count    (err_count),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Register-block responder: ready after rdy_delay access wait cycles.
  assign m_apb_pready  = m_apb_psel & m_apb_penable & (wait_cnt >= rdy_delay);
  assign m_apb_prdata  = m_apb_pready ? rdata_val : 32'h0;
  assign m_apb_pslverr = m_apb_pready & slverr_val;
  assign parity_error  = m_apb_psel & m_apb_penable & m_apb_pready & ~m_apb_pwrite
                         & perr_mask[m_apb_paddr[3:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_apb_psel && m_apb_penable && !m_apb_pready) wait_cnt <= wait_cnt + 1;
    else                                              wait_cnt <= 0;
  end

  // Log read completions while the scrub-only window is open.
  always @(negedge clk) begin
    if (mon_en && m_apb_psel && m_apb_penable && m_apb_pready && !m_apb_pwrite) begin
      q_addr.push_back(m_apb_paddr);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic host_set(input logic [AW-1:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] sb, input logic [2:0] pr);
    s_apb_psel    = 1'b1;
    s_apb_penable = 1'b0;
    s_apb_pwrite  = wr;
    s_apb_paddr   = a;
    s_apb_pwdata  = wd;
    s_apb_pstrb   = sb;
    s_apb_pprot   = pr;
  endtask

  task automatic host_drop();
    s_apb_psel    = 1'b0;
    s_apb_penable = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [31:0] rd);
    int lat;
    host_set(a, 1'b0, 32'h0, 4'h0, 3'b000);
    step();
    s_apb_penable = 1'b1;
    lat = 1;
    #1;
    while (!s_apb_pready && lat < 50) begin
      step();
      lat++;
      #1;
    end
    rd = s_apb_prdata;
    check_eq("host_rd_done", {31'b0, s_apb_pready}, 32'd1);
    step();
    host_drop();
  endtask

  task automatic wait_scrubs(input int n, input int budget);
    int k;
    k = 0;
    while (q_addr.size() < n && k < budget) begin
      step();
      k++;
    end
    check_eq("scrub_count_reached", {31'b0, q_addr.size() >= n}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [AW-1:0] exp_addr[5];
    int c0;

    rst = 1'b1; host_drop(); s_apb_pwrite = 1'b0; s_apb_paddr = '0;
    s_apb_pwdata = 32'h0; s_apb_pstrb = 4'h0; s_apb_pprot = 3'b000;
    scrub_enable = 1'b0; err_clear = 1'b0;

    // reset state
    step();
    do_reset();
    #1;
    check_eq("rst_m_psel", {31'b0, m_apb_psel}, 32'd0);
    check_eq("rst_m_paddr", {19'b0, m_apb_paddr}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_err_valid", {31'b0, err_valid}, 32'd0);
    check_eq("rst_err_addr", {19'b0, err_addr}, 32'd0);
    check_eq("rst_s_pready", {31'b0, s_apb_pready}, 32'd0);
`ifdef PARITY_ERR_COUNT_EN
    check_eq("rst_err_count", {16'b0, err_count}, 32'd0);
`endif

    // host read 0x008, zero wait states
    step();
    host_set(13'h008, 1'b0, 32'h0, 4'h0, 3'b000);
    #1 check_eq("h_rd_idle_psel", {31'b0, m_apb_psel}, 32'd0);
    step(); s_apb_penable = 1'b1;
    #1 check_eq("h_rd_setup_psel", {31'b0, m_apb_psel}, 32'd1);
    check_eq("h_rd_setup_pen", {31'b0, m_apb_penable}, 32'd0);
    check_eq("h_rd_setup_addr", {19'b0, m_apb_paddr}, 32'h008);
    check_eq("h_rd_setup_sready", {31'b0, s_apb_pready}, 32'd0);
    step();
    #1 check_eq("h_rd_acc_pen", {31'b0, m_apb_penable}, 32'd1);
    check_eq("h_rd_acc_sready", {31'b0, s_apb_pready}, 32'd1);
    check_eq("h_rd_acc_prdata", s_apb_prdata, 32'hDEADBEEF);
    step(); host_drop();
    #1 check_eq("h_rd_after_busy", {31'b0, busy}, 32'd0);
    check_eq("h_rd_after_psel", {31'b0, m_apb_psel}, 32'd0);

    // host write with one wait state and slave error
    rdy_delay = 1; slverr_val = 1'b1;
    host_set(13'h010, 1'b1, 32'h12345678, 4'b0101, 3'b010);
    step(); s_apb_penable = 1'b1;
    #1 check_eq("h_wr_pwrite", {31'b0, m_apb_pwrite}, 32'd1);
    check_eq("h_wr_pwdata", m_apb_pwdata, 32'h12345678);
    check_eq("h_wr_pstrb", {28'b0, m_apb_pstrb}, 32'h5);
    check_eq("h_wr_pprot", {29'b0, m_apb_pprot}, 32'h2);
    check_eq("h_wr_paddr", {19'b0, m_apb_paddr}, 32'h010);
    step();
    #1 check_eq("h_wr_wait_sready", {31'b0, s_apb_pready}, 32'd0);
    step();
    #1 check_eq("h_wr_done_sready", {31'b0, s_apb_pready}, 32'd1);
    check_eq("h_wr_done_slverr", {31'b0, s_apb_pslverr}, 32'd1);
    step(); host_drop(); rdy_delay = 0; slverr_val = 1'b0;

    // periodic scrub: interval 8, four registers
    do_reset();
    q_addr.delete(); q_cyc.delete();
    mon_en = 1'b1; scrub_enable = 1'b1; c0 = cyc;
    wait_scrubs(5, 100);
    scrub_enable = 1'b0;
    exp_addr = '{13'h0, 13'h4, 13'h8, 13'hC, 13'h0};
    if (q_addr.size() >= 5) begin
      check_eq("scrub_first_latency", q_cyc[0] - c0, 32'd10);
      for (int i = 0; i < 5; i++)
        check_eq($sformatf("scrub_addr_%0d", i), {19'b0, q_addr[i]}, {19'b0, exp_addr[i]});
      for (int i = 1; i < 5; i++)
        check_eq($sformatf("scrub_period_%0d", i), q_cyc[i] - q_cyc[i-1], 32'd8);
    end
    repeat (20) step();
    check_eq("scrub_stops_when_disabled", q_addr.size(), 32'd5);
    mon_en = 1'b0;

    // simultaneous host and scrub request: host first
    do_reset();
    scrub_enable = 1'b1;
    repeat (8) step();
    host_set(13'h00C, 1'b0, 32'h0, 4'h0, 3'b000);
    #1 check_eq("arb_idle_busy", {31'b0, busy}, 32'd0);
    step(); s_apb_penable = 1'b1;
    #1 check_eq("arb_host_first_addr", {19'b0, m_apb_paddr}, 32'h00C);
    check_eq("arb_host_first_psel", {31'b0, m_apb_psel}, 32'd1);
    step();
    #1 check_eq("arb_host_done", {31'b0, s_apb_pready}, 32'd1);
    step(); host_drop();
    #1 check_eq("arb_idle_gap_psel", {31'b0, m_apb_psel}, 32'd0);
    step(); rdy_delay = 3;
    #1 check_eq("arb_scrub_setup_psel", {31'b0, m_apb_psel}, 32'd1);
    check_eq("arb_scrub_setup_pen", {31'b0, m_apb_penable}, 32'd0);
    check_eq("arb_scrub_setup_addr", {19'b0, m_apb_paddr}, 32'h000);

    // host arrives during a slow scrub access and must wait
    step();
    host_set(13'h008, 1'b0, 32'h0, 4'h0, 3'b000);
    scrub_enable = 1'b0;
    #1 check_eq("wait_scrub_pen", {31'b0, m_apb_penable}, 32'd1);
    check_eq("wait_sready_0", {31'b0, s_apb_pready}, 32'd0);
    step(); s_apb_penable = 1'b1;
    #1 check_eq("wait_sready_1", {31'b0, s_apb_pready}, 32'd0);
    step();
    #1 check_eq("wait_sready_2", {31'b0, s_apb_pready}, 32'd0);
    step();
    #1 check_eq("wait_scrub_done_addr", {19'b0, m_apb_paddr}, 32'h000);
    check_eq("wait_sready_3", {31'b0, s_apb_pready}, 32'd0);
    rdy_delay = 0;
    step();
    #1 check_eq("wait_idle_busy", {31'b0, busy}, 32'd0);
    check_eq("wait_idle_sready", {31'b0, s_apb_pready}, 32'd0);
    step();
    #1 check_eq("wait_host_setup_addr", {19'b0, m_apb_paddr}, 32'h008);
    check_eq("wait_host_setup_pen", {31'b0, m_apb_penable}, 32'd0);
    step();
    #1 check_eq("wait_host_done", {31'b0, s_apb_pready}, 32'd1);
    check_eq("wait_host_prdata", s_apb_prdata, 32'hDEADBEEF);
    step(); host_drop();

    // parity capture: scrub read 0x4 first, then host read 0xC
    do_reset();
    perr_mask = 4'b1010;
    q_addr.delete(); q_cyc.delete();
    mon_en = 1'b1; scrub_enable = 1'b1;
    wait_scrubs(2, 60);
    scrub_enable = 1'b0; mon_en = 1'b0;
    step(); step();
    check_eq("perr_scrub_valid", {31'b0, err_valid}, 32'd1);
    check_eq("perr_scrub_addr", {19'b0, err_addr}, 32'h004);
    check_eq("perr_scrub_src", {31'b0, err_src}, 32'd1);
    host_read(13'h00C, rd);
    #1 check_eq("perr_first_kept_addr", {19'b0, err_addr}, 32'h004);
    check_eq("perr_first_kept_src", {31'b0, err_src}, 32'd1);
`ifdef PARITY_ERR_COUNT_EN
    check_eq("perr_count_2", {16'b0, err_count}, 32'd2);
`endif
    step(); err_clear = 1'b1;
    step(); err_clear = 1'b0;
    #1 check_eq("perr_cleared", {31'b0, err_valid}, 32'd0);
`ifdef PARITY_ERR_COUNT_EN
    check_eq("perr_count_cleared", {16'b0, err_count}, 32'd0);
`endif
    host_read(13'h00C, rd);
    #1 check_eq("perr_host_valid", {31'b0, err_valid}, 32'd1);
    check_eq("perr_host_addr", {19'b0, err_addr}, 32'h00C);
    check_eq("perr_host_src", {31'b0, err_src}, 32'd0);

    // clear coinciding with a new error captures the new error
    host_set(13'h004, 1'b0, 32'h0, 4'h0, 3'b000);
    step(); s_apb_penable = 1'b1;
    step(); err_clear = 1'b1;
    #1 check_eq("clr_new_sready", {31'b0, s_apb_pready}, 32'd1);
    step(); err_clear = 1'b0; host_drop();
    #1 check_eq("clr_new_valid", {31'b0, err_valid}, 32'd1);
    check_eq("clr_new_addr", {19'b0, err_addr}, 32'h004);
    check_eq("clr_new_src", {31'b0, err_src}, 32'd0);
`ifdef PARITY_ERR_COUNT_EN
    check_eq("clr_new_count", {16'b0, err_count}, 32'd1);
`endif
    perr_mask = 4'h0;

    // reset during a stalled host access
    rdy_delay = 10;
    host_set(13'h008, 1'b0, 32'h0, 4'h0, 3'b000);
    step(); s_apb_penable = 1'b1;
    step();
    #1 check_eq("abort_in_access", {31'b0, m_apb_penable}, 32'd1);
    rst = 1'b1;
    #1 check_eq("abort_rst_cycle_sready", {31'b0, s_apb_pready}, 32'd0);
    step(); rst = 1'b0; host_drop();
    #1 check_eq("abort_m_psel", {31'b0, m_apb_psel}, 32'd0);
    check_eq("abort_m_penable", {31'b0, m_apb_penable}, 32'd0);
    check_eq("abort_m_paddr", {19'b0, m_apb_paddr}, 32'd0);
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_sready", {31'b0, s_apb_pready}, 32'd0);
    check_eq("abort_err_valid", {31'b0, err_valid}, 32'd0);
    rdy_delay = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_parity_scrub_arb.md
APB_PARITY_SCRUB_ARB -- requirements
Module: apb_parity_scrub_arb

Interface
REQ-001 SHALL have parameter G_ADDR_WIDTH, default 13, APB address width.
REQ-002 SHALL have parameter G_NUM_REGS, default 16, number of 32-bit registers scrubbed (addresses 0, 4, ... 4*(G_NUM_REGS-1)).
REQ-003 SHALL have parameter G_SCRUB_INTERVAL, default 1024, clk cycles between scrub requests (min 4).
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports s_apb_psel/penable/pwrite  in  1 each; s_apb_pprot  in  3; s_apb_paddr  in  G_ADDR_WIDTH; s_apb_pwdata  in  32; s_apb_pstrb  in  4  host APB slave request.
REQ-007 SHALL have ports s_apb_pready  out  1; s_apb_prdata  out  32; s_apb_pslverr  out  1  host APB slave response.
REQ-008 SHALL have ports m_apb_psel/penable/pwrite  out  1 each; m_apb_pprot  out  3; m_apb_paddr  out  G_ADDR_WIDTH; m_apb_pwdata  out  32; m_apb_pstrb  out  4  master to register block.
REQ-009 SHALL have ports m_apb_pready  in  1; m_apb_prdata  in  32; m_apb_pslverr  in  1  register block response.
REQ-010 SHALL have port parity_error  in  1  register block parity flag, valid on read completion cycle.
REQ-011 SHALL have ports scrub_enable  in  1; err_clear  in  1 (pulse); err_valid  out  1; err_addr  out  G_ADDR_WIDTH; err_src  out  1 (0 host, 1 scrub); busy  out  1 (FSM not IDLE).

Function
REQ-012 SHALL implement FSM states IDLE, HOST_SETUP, HOST_ACCESS, SCRUB_SETUP, SCRUB_ACCESS.
REQ-013 IDLE: s_apb_psel=1 -> HOST_SETUP, latching host paddr/pwdata/pwrite/pstrb/pprot; else scrub_pending=1 -> SCRUB_SETUP; host wins simultaneous requests.
REQ-014 *_SETUP: m_apb_psel=1, m_apb_penable=0; next cycle unconditionally -> matching *_ACCESS.
REQ-015 *_ACCESS: m_apb_psel=1, m_apb_penable=1, held until m_apb_pready=1, then -> IDLE.
REQ-016 HOST_ACCESS with m_apb_pready=1: s_apb_pready=1 same cycle (combinational), s_apb_prdata/pslverr = m_apb_prdata/pslverr; s_apb_pready=0 in all other cycles; min host latency 2 cycles after psel seen in IDLE.
REQ-017 Host request arriving during scrub SHALL wait (s_apb_pready=0) until scrub completes; scrub is never aborted.
REQ-018 Scrub accesses: pwrite=0, pstrb=0, pprot=0, pwdata=0, paddr=4*scrub_idx; m_apb_pslverr ignored.
REQ-019 scrub_idx SHALL increment on each scrub completion, wrapping G_NUM_REGS-1 -> 0.
REQ-020 Interval counter SHALL count while scrub_enable=1, set scrub_pending on reaching G_SCRUB_INTERVAL-1 and restart at 0; counter holds and pending clears when scrub_enable=0.
REQ-021 scrub_pending SHALL clear on entry to SCRUB_SETUP; expiry while already pending SHALL not queue a second request.
REQ-022 Read completion = m_apb_psel & penable & pready & !pwrite (host or scrub); parity_error sampled only then.
REQ-023 parity_error=1 at read completion with err_valid=0: err_valid<=1, err_addr<=m_apb_paddr, err_src<=source; later errors ignored while err_valid=1 (first-error capture).
REQ-024 err_clear SHALL clear err_valid; simultaneous err_clear and new error SHALL capture the new error.
REQ-025 m_apb_* SHALL all be 0 in IDLE.

Reset
REQ-026 rst=1 SHALL force FSM IDLE, scrub_idx 0, interval counter 0, scrub_pending 0, err_valid 0, err_addr 0, err_src 0, all m_apb_* and s_apb_* outputs 0 the following cycle.
REQ-027 rst mid-transfer SHALL abort the transfer; m_apb_psel=0 cycle after rst sampled; no s_apb_pready pulse issued for aborted transfer.

Configuration
REQ-028 Macro PARITY_ERR_COUNT_EN defined: add output err_count (16 bits), incremented on every parity error at read completion regardless of err_valid, saturating at 0xFFFF, cleared by rst and err_clear (clear then increment if simultaneous gives 1).
REQ-029 Macro undefined: err_count port and counter absent; all other behaviour identical.

Verification
REQ-030 Host read addr 0x008, m_apb_pready tied 1, prdata 0xDEADBEEF -> m_psel setup 1 cycle, access 1 cycle, s_apb_pready=1 with prdata 0xDEADBEEF 2 cycles after psel.
REQ-031 scrub_enable=1, G_SCRUB_INTERVAL=8, G_NUM_REGS=4 -> scrub reads at 0x0,0x4,0x8,0xC,0x0 every 8 cycles.
REQ-032 Host psel asserted same cycle as scrub_pending -> host granted first; scrub starts cycle after host completion.
REQ-033 Host psel during SCRUB_ACCESS with m_apb_pready delayed 3 cycles -> s_apb_pready stays 0 until scrub done, host completes 2 cycles later.
REQ-034 parity_error=1 on scrub read 0x4 then host read 0xC -> err_valid=1, err_addr=0x4, err_src=1; err_clear pulse -> err_valid=0 (err_count=2 when PARITY_ERR_COUNT_EN).
REQ-035 rst asserted in HOST_ACCESS with pready=0 -> next cycle all m_apb_* 0, busy=0, no s_apb_pready.
